// File: rtl/cache_pkg.sv
// Shared widths and FSM state encoding for the write-back data cache.
package cache_pkg;
    localparam int NUM_BLOCKS_DEF = 8;
    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 30;
    localparam int LADDR_W        = 28;
    localparam int OFS_W          = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;
endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: valid/dirty/tag/data arrays with one word write port and one line refill port.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int IDX_W      = $clog2(NUM_BLOCKS),
    parameter int TAG_W      = LADDR_W - IDX_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              word_wen,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [OFS_W-1:0]  word_ofs,
    input  logic [WORD_W-1:0] word_data,
    input  logic              line_wen,
    input  logic [IDX_W-1:0]  line_idx,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic [LINE_W-1:0] line_data
);
    logic              valid [NUM_BLOCKS];
    logic              dirty [NUM_BLOCKS];
    logic [TAG_W-1:0]  tag   [NUM_BLOCKS];
    logic [LINE_W-1:0] data  [NUM_BLOCKS];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tag[rd_idx];
    assign rd_line  = data[rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                valid[i] <= 1'b0;
                dirty[i] <= 1'b0;
                tag[i]   <= '0;
                data[i]  <= '0;
            end
        end else begin
            // A refill always leaves the line clean; a store hit marks it dirty.
            if (line_wen) begin
                valid[line_idx] <= 1'b1;
                dirty[line_idx] <= 1'b0;
                tag[line_idx]   <= line_tag;
                data[line_idx]  <= line_data;
            end
            if (word_wen) begin
                dirty[word_idx] <= 1'b1;
                data[word_idx][{word_ofs, 5'b0} +: WORD_W] <= word_data;
            end
        end
    end
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate cache: zero-cycle hits, stall on miss for write-back and refill.
module dcache_wb
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               proc_ren,
    input  logic               proc_wen,
    input  logic [ADDR_W-1:0]  proc_addr,
    input  logic [WORD_W-1:0]  proc_wdata,
    output logic               proc_stall,
    output logic [WORD_W-1:0]  proc_rdata,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic               mem_ready,
    input  logic [LINE_W-1:0]  mem_rdata
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = LADDR_W - IDX_W;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFS_W-1:0]  req_ofs;
    logic              req, hit, word_wen, line_wen;
    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [LADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    assign req_tag    = proc_addr[ADDR_W-1 -: TAG_W];
    assign req_idx    = proc_addr[OFS_W +: IDX_W];
    assign req_ofs    = proc_addr[OFS_W-1:0];
    assign req        = proc_ren | proc_wen;
    assign hit        = rd_valid && (rd_tag == req_tag);
    assign proc_stall = req && ((state_q != IDLE) || !hit);
    assign proc_rdata = rd_line[{req_ofs, 5'b0} +: WORD_W];
    assign word_wen   = (state_q == IDLE) && proc_wen && hit;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    cache_line_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .rd_idx    (req_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .word_wen  (word_wen),
        .word_idx  (req_idx),
        .word_ofs  (req_ofs),
        .word_data (proc_wdata),
        .line_wen  (line_wen),
        .line_idx  (miss_idx_q),
        .line_tag  (miss_tag_q),
        .line_data (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_wen    = 1'b0;
        case (state_q)
            IDLE: begin
                // The missing line is latched so a request dropped mid-miss still refills.
                if (req && !hit) begin
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    if (rd_valid && rd_dirty) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, req_idx};
                        mem_wdata_d = rd_line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_tag, req_idx};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {miss_tag_q, miss_idx_q};
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_read_d = 1'b0;
                    line_wen   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        miss_tag_q <= miss_tag_d;
        miss_idx_q <= miss_idx_d;
    end
endmodule
